// File: rtl/srg_piso_n.sv
// srg_piso_n: load/shift controlled WIDTH-bit shift register, full-duplex PISO/SIPO with bit count and done pulse.
// Optional SRG_ROTATE_EN: adds rot input; when set at load the outgoing bit refills the vacated position.
module srg_piso_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic             dir,
   input  logic             en,
   input  logic             sin,
`ifdef SRG_ROTATE_EN
   input  logic             rot,
`endif
   output logic             y,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] buffer;
   logic [WIDTH-1:0] buf_shl;
   logic [WIDTH-1:0] buf_shr;
   logic             dir_r;
   logic [CNT_W-1:0] count;
   logic             out_bit;
   logic             fill;
`ifdef SRG_ROTATE_EN
   logic             rot_r;
`endif

   // Shift by operator then patch the vacated bit, so WIDTH=1 needs no special slicing.
   always_comb begin
      out_bit = dir_r ? buffer[WIDTH-1] : buffer[0];
      fill    = sin;
`ifdef SRG_ROTATE_EN
      if (rot_r) fill = out_bit;
`endif
      buf_shl          = buffer << 1;
      buf_shl[0]       = fill;
      buf_shr          = buffer >> 1;
      buf_shr[WIDTH-1] = fill;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         buffer <= '0;
         dir_r  <= 1'b0;
         count  <= '0;
         y      <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef SRG_ROTATE_EN
         rot_r  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (ld_valid) begin
                  buffer <= x;
                  dir_r  <= dir;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= SHIFT;
`ifdef SRG_ROTATE_EN
                  rot_r  <= rot;
`endif
               end
            end
            SHIFT: begin
               if (en) begin
                  y      <= out_bit;
                  buffer <= dir_r ? buf_shl : buf_shr;
                  count  <= count + CNT_W'(1);
                  if (count == LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign q        = buffer;
   assign ld_ready = ~busy;

endmodule
